// File: rtl/serial_adder_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Requester drives operands and start, observes status and result.
    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    // Adder samples operands and start, drives status and result.
    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, carry kept in a register
// between steps, start/busy/done handshake. Result is registered and held
// until the next completion.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned DW    = DIGIT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] partial;
    logic             carry;
    logic [CW-1:0]    step;

    logic [DIGIT:0]   digit_sum_c;
    logic             carry_msb_c;
    logic [WIDTH-1:0] partial_next_c;
    logic             last_c;

    // One digit of add, its internal carry into the digit MSB, and the shifted partial result.
    always_comb begin
        digit_sum_c    = DW'(op_a[DIGIT-1:0]) + DW'(op_b[DIGIT-1:0]) + DW'(carry);
        // Sum bit = a ^ b ^ carry-in, so the carry into the digit MSB falls out by XOR.
        carry_msb_c    = digit_sum_c[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
        partial_next_c = (partial >> DIGIT) | (WIDTH'(digit_sum_c[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_c         = (step == CW'(STEPS - 1));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            partial  <= '0;
            carry    <= 1'b0;
            step     <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op_a     <= bus.a;
                        op_b     <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub ? 1'b1 : bus.cin;
                        partial  <= '0;
                        step     <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a    <= op_a >> DIGIT;
                    op_b    <= op_b >> DIGIT;
                    carry   <= digit_sum_c[DIGIT];
                    partial <= partial_next_c;
                    step    <= step + CW'(1);
                    if (last_c) begin
                        bus.sum  <= partial_next_c;
                        bus.cout <= digit_sum_c[DIGIT];
                        bus.ovf  <= carry_msb_c ^ digit_sum_c[DIGIT];
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: ten adder configurations share one stimulus bus;
// directed table, back-to-back, mid-run reset and a random sweep.
module tb_serial_adder;
    localparam int NI = 10;
    localparam int NV = 8;

    function automatic int unsigned cfg_w(int k);
        case (k)
            0, 1, 5, 6: return 8;
            2, 3, 4:    return 4;
            default:    return 16;
        endcase
    endfunction

    function automatic int unsigned cfg_d(int k);
        case (k)
            0, 2, 7: return 1;
            3, 5, 8: return 2;
            1, 4:    return 4;
            6:       return 8;
            default: return 16;
        endcase
    endfunction

    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    logic        busy_v [NI];
    logic        done_v [NI];
    logic        cout_v [NI];
    logic        ovf_v  [NI];
    logic [15:0] sum_v  [NI];

    int errors = 0;
    int checks = 0;

    for (genvar k = 0; k < NI; k++) begin : g
        localparam int unsigned GW = cfg_w(k);
        localparam int unsigned GD = cfg_d(k);
        serial_adder_if #(.WIDTH(GW)) ifc ();
        serial_adder #(.WIDTH(GW), .DIGIT(GD)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
        assign ifc.start = start;
        assign ifc.sub   = sub;
        assign ifc.cin   = cin;
        assign ifc.a     = a_drv[GW-1:0];
        assign ifc.b     = b_drv[GW-1:0];
        assign busy_v[k] = ifc.busy;
        assign done_v[k] = ifc.done;
        assign cout_v[k] = ifc.cout;
        assign ovf_v[k]  = ifc.ovf;
        assign sum_v[k]  = 16'(ifc.sum);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: full-width integer add, carry into MSB from the low WIDTH-1 bits.
    task automatic model(input int unsigned w, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c, output logic [15:0] rs,
                         output logic rc, output logic ro);
        int unsigned mask;
        int unsigned am;
        int unsigned bm;
        int unsigned c0;
        int unsigned full;
        int unsigned low;
        logic        cim;
        mask = (32'd1 << w) - 32'd1;
        am   = 32'(a) & mask;
        bm   = s ? (~32'(b) & mask) : (32'(b) & mask);
        c0   = s ? 32'd1 : 32'(c);
        full = am + bm + c0;
        low  = (am & (mask >> 1)) + (bm & (mask >> 1)) + c0;
        rs   = 16'(full & mask);
        rc   = 1'((full >> w) & 32'd1);
        cim  = 1'((low >> (w - 1)) & 32'd1);
        ro   = cim ^ rc;
    endtask

    task automatic check_int(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d, want %0d", name, k, act, exp);
        end
    endtask

    task automatic check_res(input string name, input int k, input logic [15:0] es,
                             input logic ec, input logic eo);
        checks++;
        if (sum_v[k] !== es || cout_v[k] !== ec || ovf_v[k] !== eo) begin
            errors++;
            $display("FAIL %s inst%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, k, sum_v[k], cout_v[k], ovf_v[k], es, ec, eo);
        end
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 40 && busy_v[k]; i++) begin
            @(posedge clk);
            #1;
        end
        check_int("idle_wait", k, int'(busy_v[k]), 0);
    endtask

    // Pulse start for one cycle, then watch instance k until done or timeout.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, output int lat, output int bcnt,
                          output bit held, output bit got);
        logic [15:0] prev;
        wait_idle(k);
        @(negedge clk);
        a_drv = a; b_drv = b; sub = s; cin = c; start = 1'b1;
        prev = sum_v[k];
        @(posedge clk);
        #1;
        lat  = 1;
        bcnt = int'(busy_v[k]);
        held = 1'b1;
        got  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a_drv = 16'($urandom);
        b_drv = 16'($urandom);
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_v[k]) got = 1'b1;
            else begin
                bcnt += int'(busy_v[k]);
                if (sum_v[k] !== prev) held = 1'b0;
            end
        end
    endtask

    initial begin
        vec_t        vecs [NV];
        int          lat;
        int          bcnt;
        int          n;
        bit          held;
        bit          got;
        bit          seen;
        bit          bad_done;
        logic [15:0] ra, rb, es;
        logic        rsub, rcin, ec, eo;
        logic [NI-1:0] gotmask;

        vecs[0] = '{0, 16'h0035, 16'h004A, 1'b0, 1'b0, 16'h007F, 1'b0, 1'b0};
        vecs[1] = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[2] = '{0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
        vecs[3] = '{1, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0};
        vecs[4] = '{1, 16'h0080, 16'h0001, 1'b1, 1'b1, 16'h007F, 1'b1, 1'b1};
        vecs[5] = '{4, 16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1};
        vecs[6] = '{9, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[7] = '{7, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a_drv = '0; b_drv = '0;

        // Reset state of every configuration.
        #1;
        for (int k = 0; k < NI; k++) begin
            check_int("reset_ctrl", k, int'({busy_v[k], done_v[k]}), 0);
            check_res("reset_out", k, 16'h0, 1'b0, 1'b0);
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: latency, busy length, held output, result.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat, bcnt, held, got);
            n = int'(cfg_w(vecs[i].k) / cfg_d(vecs[i].k));
            check_int("dir_done_seen", vecs[i].k, int'(got), 1);
            if (got) begin
                check_int("dir_latency", vecs[i].k, lat, n + 1);
                check_int("dir_busy_cycles", vecs[i].k, bcnt, n);
                check_int("dir_sum_held", vecs[i].k, int'(held), 1);
                check_res("dir_result", vecs[i].k, vecs[i].s, vecs[i].co, vecs[i].ov);
            end
        end

        // Back-to-back on 8/1: start held high, operands change every cycle.
        wait_idle(0);
        bad_done = 1'b0;
        ra = '0; rb = '0; rsub = 1'b0; rcin = 1'b0;
        for (int t = 0; t < 27; t++) begin
            @(negedge clk);
            a_drv = 16'($urandom); b_drv = 16'($urandom);
            sub = 1'($urandom); cin = 1'($urandom); start = 1'b1;
            if (t % 9 == 0) begin
                ra = a_drv; rb = b_drv; rsub = sub; rcin = cin;
            end
            @(posedge clk);
            #1;
            if (t % 9 == 8) begin
                check_int("b2b_done", 0, int'(done_v[0]), 1);
                model(8, ra, rb, rsub, rcin, es, ec, eo);
                check_res("b2b_result", 0, es, ec, eo);
            end else if (done_v[0]) begin
                bad_done = 1'b1;
            end
        end
        check_int("b2b_no_extra_done", 0, int'(bad_done), 0);
        @(negedge clk);
        start = 1'b0;

        // Asynchronous reset three steps into an 8-step run.
        run_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, lat, bcnt, held, got);
        check_res("pre_reset_result", 0, 16'h0080, 1'b0, 1'b1);
        @(negedge clk);
        a_drv = 16'h0035; b_drv = 16'h004A; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_int("pre_reset_busy", 0, int'(busy_v[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("mid_reset_ctrl", 0, int'({busy_v[0], done_v[0]}), 0);
        check_res("mid_reset_out", 0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_v[0]) seen = 1'b1;
        end
        check_int("no_done_after_reset", 0, int'(seen), 0);

        // Random sweep: all configurations started together on the same operands.
        for (int k = 0; k < NI; k++) wait_idle(k);
        for (int r = 0; r < 1000; r++) begin
            @(negedge clk);
            a_drv = 16'($urandom); b_drv = 16'($urandom);
            sub = 1'($urandom); cin = 1'($urandom); start = 1'b1;
            ra = a_drv; rb = b_drv; rsub = sub; rcin = cin;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            a_drv = 16'($urandom); b_drv = 16'($urandom);
            gotmask = '0;
            for (int i = 0; i < 24 && !(&gotmask); i++) begin
                @(posedge clk);
                #1;
                for (int k = 0; k < NI; k++) if (done_v[k]) gotmask[k] = 1'b1;
            end
            for (int k = 0; k < NI; k++) begin
                check_int("sweep_done_seen", k, int'(gotmask[k]), 1);
                if (gotmask[k]) begin
                    model(cfg_w(k), ra, rb, rsub, rcin, es, ec, eo);
                    check_res("sweep_result", k, es, ec, eo);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
